// File: rtl/deserial_if.sv
// deserial_if -- serial-in / parallel-out bus between a bit source and the
// deserializer.
//   i_val  serial data bit          i_stp  bit strobe
//   i_syn  word-alignment marker    i_rdy  downstream ready
//   i_clr  clear sticky overflow
//   o_val  parallel word            o_stp  word valid (held until consumed)
//   o_cnt  bits in partial word     o_ovf  sticky overflow
// master: bit source / consumer side; slave: the deserializer.
interface deserial_if #(
   parameter int p_width = 8
) ();
   logic                           i_val;
   logic                           i_stp;
   logic                           i_syn;
   logic                           i_rdy;
   logic                           i_clr;
   logic [p_width-1:0]             o_val;
   logic                           o_stp;
   logic [$clog2(p_width+1)-1:0]   o_cnt;
   logic                           o_ovf;

   modport master (
      output i_val, i_stp, i_syn, i_rdy, i_clr,
      input  o_val, o_stp, o_cnt, o_ovf
   );

   modport slave (
      input  i_val, i_stp, i_syn, i_rdy, i_clr,
      output o_val, o_stp, o_cnt, o_ovf
   );
endinterface

// File: rtl/deserial.sv
// deserial -- LSB-first serial-to-parallel converter with a one-word holding
// register, ready/valid output and sticky overflow.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-low reset
//   bus    deserial_if.slave (serial input, handshake, parallel output)
//
// Receive FSM
//   state | meaning
//   IDLE  | no bits of a word held, o_cnt = 0
//   RECV  | partial word held, 0 < o_cnt < p_width
// Output FSM
//   state | meaning
//   EMPTY | no word held, o_stp = 0
//   FULL  | word held on o_val, o_stp = 1 until consumed
module deserial #(
   parameter int p_width = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   deserial_if.slave  bus
);
   localparam int CW = $clog2(p_width + 1);
   localparam logic [CW-1:0] c_last = CW'(p_width - 1);

   typedef enum logic { RX_IDLE, RX_RECV } rx_state_t;
   typedef enum logic { OUT_EMPTY, OUT_FULL } out_state_t;

   rx_state_t          rx_state_q, rx_state_d;
   out_state_t         out_state_q, out_state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [p_width-1:0] shift_q, shift_d;
   logic [p_width-1:0] word_q, word_d;
   logic               ovf_q, ovf_d;

   logic               complete;
   logic [p_width-1:0] shifted;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         rx_state_q  <= RX_IDLE;
         out_state_q <= OUT_EMPTY;
         cnt_q       <= '0;
         shift_q     <= '0;
         word_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         out_state_q <= out_state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         word_q      <= word_d;
         ovf_q       <= ovf_d;
      end
   end

   // Bits enter at the MSB and move right, so after p_width strobes the
   // first bit has reached bit 0.
   assign shifted = {bus.i_val, shift_q[p_width-1:1]};

   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      complete   = 1'b0;
      if (bus.i_syn) begin
         if (bus.i_stp) begin
            // New word starts with this bit; p_width >= 2 so it cannot complete.
            shift_d    = {bus.i_val, {(p_width-1){1'b0}}};
            cnt_d      = CW'(1);
            rx_state_d = RX_RECV;
         end else begin
            shift_d    = '0;
            cnt_d      = '0;
            rx_state_d = RX_IDLE;
         end
      end else if (bus.i_stp) begin
         if (cnt_q == c_last) begin
            complete   = 1'b1;
            shift_d    = '0;
            cnt_d      = '0;
            rx_state_d = RX_IDLE;
         end else begin
            shift_d    = shifted;
            cnt_d      = cnt_q + CW'(1);
            rx_state_d = RX_RECV;
         end
      end
   end

   always_comb begin
      out_state_d = out_state_q;
      word_d      = word_q;
      ovf_d       = ovf_q;
      if (bus.i_clr) begin
         ovf_d = 1'b0;
      end
      case (out_state_q)
         OUT_EMPTY: begin
            if (complete) begin
               word_d      = shifted;
               out_state_d = OUT_FULL;
            end
         end
         OUT_FULL: begin
            if (complete && bus.i_rdy) begin
               word_d = shifted;
            end else if (complete) begin
               // New word dropped; overflow set takes priority over clear.
               ovf_d = 1'b1;
            end else if (bus.i_rdy) begin
               out_state_d = OUT_EMPTY;
            end
         end
         default: out_state_d = OUT_EMPTY;
      endcase
   end

   assign bus.o_val = word_q;
   assign bus.o_stp = (out_state_q == OUT_FULL);
   assign bus.o_cnt = cnt_q;
   assign bus.o_ovf = ovf_q;
endmodule

// File: tb/tb_deserial.sv
module tb_deserial;
   localparam int W = 8;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;

   always #5 i_clk = ~i_clk;

   deserial_if #(.p_width(W)) bus ();

   deserial #(.p_width(W)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: a word is new when o_stp rises or when the previous
   // word was consumed and o_stp stayed high.
   logic last_stp  = 1'b0;
   logic last_cons = 1'b0;
   always @(negedge i_clk) begin
      if (bus.o_stp && (!last_stp || last_cons)) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_word", 32'(bus.o_val), 32'hDEAD);
         end else begin
            chk("sb_word", 32'(bus.o_val), 32'(sb_q.pop_front()));
         end
      end
      last_stp  = bus.o_stp;
      last_cons = bus.o_stp && bus.i_rdy;
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Idle gap cycles first, then one strobe cycle; returns 1 time unit after
   // the strobe's edge with the strobe removed.
   task automatic send_bit(input logic v, input logic syn, input int gap);
      for (int g = 0; g < gap; g++) begin
         bus.i_stp = 1'b0;
         bus.i_val = 1'($urandom_range(0, 1));
         step();
      end
      bus.i_val = v;
      bus.i_syn = syn;
      bus.i_stp = 1'b1;
      step();
      bus.i_stp = 1'b0;
      bus.i_syn = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) send_bit(w[i], 1'b0, $urandom_range(0, 2));
   endtask

   task automatic send_rand_bits(input int n);
      for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] w;
      bus.i_val = 1'b0;
      bus.i_stp = 1'b0;
      bus.i_syn = 1'b0;
      bus.i_rdy = 1'b0;
      bus.i_clr = 1'b0;
      i_rst     = 1'b0;
      step();
      step();
      @(negedge i_clk);
      chk("rst_val", 32'(bus.o_val), 0);
      chk("rst_stp", 32'(bus.o_stp), 0);
      chk("rst_cnt", 32'(bus.o_cnt), 0);
      chk("rst_ovf", 32'(bus.o_ovf), 0);
      i_rst = 1'b1;
      step();

      // 0xA5 with ready high: o_stp for exactly one cycle
      bus.i_rdy = 1'b1;
      w = 8'hA5;
      sb_q.push_back(w);
      for (int i = 0; i < 8; i++) begin
         send_bit(w[i], 1'b0, $urandom_range(0, 3));
         if (i == 3) chk("a5_cnt4", 32'(bus.o_cnt), 4);
      end
      @(negedge i_clk);
      chk("a5_stp", 32'(bus.o_stp), 1);
      chk("a5_val", 32'(bus.o_val), 32'hA5);
      chk("a5_cnt0", 32'(bus.o_cnt), 0);
      step();
      @(negedge i_clk);
      chk("a5_stp_drop", 32'(bus.o_stp), 0);

      // Overflow: 0x3C held, 0x81 dropped
      bus.i_rdy = 1'b0;
      sb_q.push_back(8'h3C);
      send_word(8'h3C);
      send_word(8'h81);
      @(negedge i_clk);
      chk("ovf_val", 32'(bus.o_val), 32'h3C);
      chk("ovf_stp", 32'(bus.o_stp), 1);
      chk("ovf_set", 32'(bus.o_ovf), 1);
      bus.i_clr = 1'b1;
      step();
      bus.i_clr = 1'b0;
      @(negedge i_clk);
      chk("ovf_clr", 32'(bus.o_ovf), 0);
      chk("ovf_hold_stp", 32'(bus.o_stp), 1);
      bus.i_rdy = 1'b1;
      step();
      @(negedge i_clk);
      chk("ovf_drain", 32'(bus.o_stp), 0);

      // Consume and complete in the same cycle
      bus.i_rdy = 1'b0;
      sb_q.push_back(8'h11);
      send_word(8'h11);
      sb_q.push_back(8'h22);
      w = 8'h22;
      for (int i = 0; i < 7; i++) send_bit(w[i], 1'b0, $urandom_range(0, 2));
      bus.i_rdy = 1'b1;
      send_bit(w[7], 1'b0, 0);
      @(negedge i_clk);
      chk("cc_val", 32'(bus.o_val), 32'h22);
      chk("cc_stp", 32'(bus.o_stp), 1);
      chk("cc_ovf", 32'(bus.o_ovf), 0);
      step();
      @(negedge i_clk);
      chk("cc_drain", 32'(bus.o_stp), 0);

      // Resync with a strobe mid-word
      send_rand_bits(3);
      @(negedge i_clk);
      chk("syn_cnt3", 32'(bus.o_cnt), 3);
      send_bit(1'b1, 1'b1, 0);
      @(negedge i_clk);
      chk("syn_cnt1", 32'(bus.o_cnt), 1);
      sb_q.push_back(8'hFF);
      for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, $urandom_range(0, 2));
      step();

      // Reset mid-word
      send_rand_bits(5);
      i_rst = 1'b0;
      step();
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("rstmid_cnt", 32'(bus.o_cnt), 0);
      chk("rstmid_stp", 32'(bus.o_stp), 0);
      sb_q.push_back(8'h5A);
      send_word(8'h5A);
      step();

      // Reset while FULL drops the held word
      bus.i_rdy = 1'b0;
      sb_q.push_back(8'h77);
      send_word(8'h77);
      i_rst = 1'b0;
      step();
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("rstfull_stp", 32'(bus.o_stp), 0);
      chk("rstfull_val", 32'(bus.o_val), 0);

      // Sync without strobe while a word is held
      sb_q.push_back(8'h96);
      send_word(8'h96);
      send_rand_bits(6);
      bus.i_syn = 1'b1;
      step();
      bus.i_syn = 1'b0;
      @(negedge i_clk);
      chk("synonly_cnt", 32'(bus.o_cnt), 0);
      chk("synonly_stp", 32'(bus.o_stp), 1);
      chk("synonly_val", 32'(bus.o_val), 32'h96);
      bus.i_rdy = 1'b1;
      step();
      sb_q.push_back(8'hC3);
      send_word(8'hC3);
      step();
      step();

      chk("sb_empty", 32'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/deserial.md
DESERIAL -- requirements
Module: deserial

Interface
REQ-001 The block SHALL have parameter p_width, default 8, meaning the parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL have port i_clk  input  1  single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port i_val  input  1  serial data bit, sampled only when i_stp=1.
REQ-005 The block SHALL have port i_stp  input  1  bit strobe, one serial bit per cycle with i_stp=1; gaps of any length between strobes are legal.
REQ-006 The block SHALL have port i_syn  input  1  word-alignment marker; the current cycle starts a new word.
REQ-007 The block SHALL have port i_rdy  input  1  downstream ready; a word is consumed in a cycle with o_stp=1 and i_rdy=1.
REQ-008 The block SHALL have port i_clr  input  1  clears the sticky overflow flag.
REQ-009 The block SHALL have port o_val  output  p_width  assembled parallel word.
REQ-010 The block SHALL have port o_stp  output  1  word valid; held until consumed.
REQ-011 The block SHALL have port o_cnt  output  $clog2(p_width+1)  bits held in the current partial word.
REQ-012 The block SHALL have port o_ovf  output  1  sticky overflow flag.

Function
REQ-013 Bit order SHALL be LSB first: the first strobed bit of a word lands in o_val[0], the p_width-th lands in o_val[p_width-1].
REQ-014 Receive side SHALL be a shift register plus bit counter with states IDLE (o_cnt=0) and RECV (0<o_cnt<p_width).
REQ-015 On i_stp=1 and i_syn=0 the block SHALL shift in i_val and increment o_cnt, moving IDLE->RECV.
REQ-016 On the strobe that makes the word complete, the block SHALL return o_cnt to 0 (RECV->IDLE) in the same edge; o_cnt never reads p_width.
REQ-017 Cycles with i_stp=0 SHALL leave the shift register and o_cnt unchanged.
REQ-018 Output side SHALL be a one-word holding register with states EMPTY (o_stp=0) and FULL (o_stp=1).
REQ-019 A completed word SHALL load o_val and set o_stp on the same edge as the completing strobe; latency is 1 cycle from the last bit's strobe cycle to o_stp=1.
REQ-020 In FULL, o_val SHALL be held stable until consumed; consumption with no new completion SHALL return to EMPTY on the next edge.
REQ-021 When consumption and completion occur in the same cycle, the new word SHALL be loaded and o_stp SHALL stay 1, with no overflow.
REQ-022 When a word completes in FULL without consumption, the new word SHALL be dropped, o_val SHALL remain unchanged, and o_ovf SHALL be set on that edge.
REQ-023 o_ovf SHALL stay set until i_clr=1 or reset; if i_clr and a new overflow coincide, set SHALL win.
REQ-024 When i_syn=1 and i_stp=1, the block SHALL discard any partial word and take i_val as bit 0 of a new word, giving o_cnt=1.
REQ-025 For p_width... the case of i_syn=1 and i_stp=1 SHALL never complete a word, since p_width>=2.
REQ-026 When i_syn=1 and i_stp=0, the block SHALL discard the partial word and set o_cnt=0.
REQ-027 i_syn SHALL never affect the output side (o_val, o_stp, o_ovf).
REQ-028 Discarded partial words SHALL NOT set o_ovf.

Reset
REQ-029 While i_rst=0 at a rising edge, the block SHALL set o_val=0, o_stp=0, o_cnt=0, o_ovf=0, clear the shift register, and ignore all other inputs.
REQ-030 Reset mid-word SHALL discard the partial word, and reset in FULL SHALL drop the held word.
REQ-031 The first strobe after reset release SHALL be bit 0 of a new word.

Verification (p_width=8)
REQ-032 With i_rdy=1, strobe bits 1,0,1,0,0,1,0,1 with random gaps -> o_val=0xA5 and o_stp=1 for exactly one cycle, starting the cycle after the 8th strobe; o_cnt then reads 0.
REQ-033 With i_rdy=0, send 0x3C then 0x81 -> o_val=0x3C, o_stp=1, o_ovf=1 after the 8th bit of 0x81; pulse i_clr -> o_ovf=0.
REQ-034 With o_stp=1 holding 0x11, assert i_rdy in the same cycle as the last strobe of 0x22 -> o_val=0x22, o_stp stays 1, o_ovf=0.
REQ-035 Send 3 bits, then i_syn+i_stp with bit 1, then 7 bits of 1 -> o_cnt=1 after the sync, and word 0xFF delivered.
REQ-036 Send 5 bits, then i_rst=0 for one cycle -> o_cnt=0, o_stp=0; the next 8 bits 0x5A yield o_val=0x5A.
REQ-037 i_syn without i_stp after 6 bits -> o_cnt=0, o_stp unaffected; the next 8 bits form a clean word.
